// File: rtl/arm_pkg.sv
// Shared ARM-subset decode constants: ALU commands, opcodes, modes, condition codes.
package arm_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 4;
  localparam int unsigned NUM_REGS = 15;
  localparam int unsigned EXE_W    = 4;

  localparam logic [EXE_W-1:0] EXE_NOP = 4'b0000;
  localparam logic [EXE_W-1:0] EXE_MOV = 4'b0001;
  localparam logic [EXE_W-1:0] EXE_ADD = 4'b0010;
  localparam logic [EXE_W-1:0] EXE_ADC = 4'b0011;
  localparam logic [EXE_W-1:0] EXE_SUB = 4'b0100;
  localparam logic [EXE_W-1:0] EXE_SBC = 4'b0101;
  localparam logic [EXE_W-1:0] EXE_AND = 4'b0110;
  localparam logic [EXE_W-1:0] EXE_ORR = 4'b0111;
  localparam logic [EXE_W-1:0] EXE_EOR = 4'b1000;
  localparam logic [EXE_W-1:0] EXE_MVN = 4'b1001;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  typedef enum logic [1:0] {
    MODE_ALU = 2'b00,
    MODE_MEM = 2'b01,
    MODE_BR  = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
  } cond_e;

  typedef struct packed {
    logic             wb_en;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             b;
    logic             s;
    logic [EXE_W-1:0] exe_cmd;
  } ctrl_t;

  // Evaluate a condition code against flags {N,Z,C,V}.
  function automatic logic cond_pass(input cond_e c, input logic [3:0] sr);
    logic n, z, cf, v;
    {n, z, cf, v} = sr;
    case (c)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = ~z;
      COND_CS: cond_pass = cf;
      COND_CC: cond_pass = ~cf;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = ~n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = ~v;
      COND_HI: cond_pass = cf & ~z;
      COND_LS: cond_pass = ~cf | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = ~z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// IF/ID inputs, write-back port and ID/EXE outputs of the decode stage.
interface id_stage_if;
  import arm_pkg::*;

  logic [XLEN-1:0]   instruction;
  logic [XLEN-1:0]   pc_in;
  logic [3:0]        sr;
  logic              hazard;
  logic              wb_wb_en;
  logic [REG_AW-1:0] wb_dest;
  logic [XLEN-1:0]   wb_value;

  logic              wb_en;
  logic              mem_r_en;
  logic              mem_w_en;
  logic              b;
  logic              s;
  logic [EXE_W-1:0]  exe_cmd;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   value_rn;
  logic [XLEN-1:0]   value_rm;
  logic [11:0]       shift_operand;
  logic              imm;
  logic [23:0]       imm_signed_24;
  logic [REG_AW-1:0] dest;
  logic [REG_AW-1:0] src_1;
  logic [REG_AW-1:0] src_2;
  logic              two_src;

  modport master (
    output instruction, pc_in, sr, hazard, wb_wb_en, wb_dest, wb_value,
    input  wb_en, mem_r_en, mem_w_en, b, s, exe_cmd, pc, value_rn, value_rm,
           shift_operand, imm, imm_signed_24, dest, src_1, src_2, two_src
  );

  modport slave (
    input  instruction, pc_in, sr, hazard, wb_wb_en, wb_dest, wb_value,
    output wb_en, mem_r_en, mem_w_en, b, s, exe_cmd, pc, value_rn, value_rm,
           shift_operand, imm, imm_signed_24, dest, src_1, src_2, two_src
  );
endinterface

// File: rtl/register_file.sv
// R0-R14 register file: two async read ports with write-through, one write port; R15 reads 0.
module register_file
  import arm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rd_addr_1,
  input  logic [REG_AW-1:0] rd_addr_2,
  output logic [XLEN-1:0]   rd_data_1,
  output logic [XLEN-1:0]   rd_data_2,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data
);

  localparam logic [REG_AW-1:0] PC_IDX = REG_AW'(15);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en && (wr_addr == REG_AW'(i))) regs_d[i] = wr_data;
    end
  end

  // Reset seeds each register with its own index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= XLEN'(i);
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd_data_1 = (rd_addr_1 == PC_IDX)                ? '0      :
                     (wr_en && (wr_addr == rd_addr_1))    ? wr_data :
                                                            regs_q[rd_addr_1];
  assign rd_data_2 = (rd_addr_2 == PC_IDX)                ? '0      :
                     (wr_en && (wr_addr == rd_addr_2))    ? wr_data :
                                                            regs_q[rd_addr_2];

endmodule

// File: rtl/id_stage.sv
// Combinational instruction decode, condition check and operand read for the ARM-subset pipeline.
module id_stage
  import arm_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  id_stage_if.slave bus
);

  mode_e             mode;
  cond_e             cond;
  logic [3:0]        opcode;
  logic              i_bit;
  logic              s_bit;
  logic [REG_AW-1:0] rn;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rm;
  ctrl_t             dec_c;
  ctrl_t             ctrl_c;
  logic              cond_ok_c;
  logic [REG_AW-1:0] src_2_c;

  assign cond   = cond_e'(bus.instruction[31:28]);
  assign mode   = mode_e'(bus.instruction[27:26]);
  assign i_bit  = bus.instruction[25];
  assign opcode = bus.instruction[24:21];
  assign s_bit  = bus.instruction[20];
  assign rn     = bus.instruction[19:16];
  assign rd     = bus.instruction[15:12];
  assign rm     = bus.instruction[3:0];

  always_comb begin
    dec_c = '0;
    case (mode)
      MODE_ALU: begin
        dec_c.wb_en = 1'b1;
        dec_c.s     = s_bit;
        case (opcode)
          OP_MOV:  dec_c.exe_cmd = EXE_MOV;
          OP_MVN:  dec_c.exe_cmd = EXE_MVN;
          OP_ADD:  dec_c.exe_cmd = EXE_ADD;
          OP_ADC:  dec_c.exe_cmd = EXE_ADC;
          OP_SUB:  dec_c.exe_cmd = EXE_SUB;
          OP_SBC:  dec_c.exe_cmd = EXE_SBC;
          OP_AND:  dec_c.exe_cmd = EXE_AND;
          OP_ORR:  dec_c.exe_cmd = EXE_ORR;
          OP_EOR:  dec_c.exe_cmd = EXE_EOR;
          OP_CMP: begin
            dec_c.exe_cmd = EXE_SUB;
            dec_c.wb_en   = 1'b0;
          end
          OP_TST: begin
            dec_c.exe_cmd = EXE_AND;
            dec_c.wb_en   = 1'b0;
          end
          default: dec_c = '0;
        endcase
      end
      MODE_MEM: begin
        dec_c.exe_cmd = EXE_ADD;
        if (s_bit) begin
          dec_c.wb_en    = 1'b1;
          dec_c.mem_r_en = 1'b1;
        end else begin
          dec_c.mem_w_en = 1'b1;
        end
      end
      MODE_BR: begin
        if (!bus.instruction[24]) dec_c.b = 1'b1;
      end
      default: dec_c = '0;
    endcase
  end

  // Stalls and failed conditions squash controls but leave the datapath fields intact.
  assign cond_ok_c = cond_pass(cond, bus.sr);
  assign ctrl_c    = (bus.hazard || !cond_ok_c) ? '{exe_cmd: EXE_NOP, default: 1'b0} : dec_c;
  assign src_2_c   = dec_c.mem_w_en ? rd : rm;

  register_file u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_1 (rn),
    .rd_addr_2 (src_2_c),
    .rd_data_1 (bus.value_rn),
    .rd_data_2 (bus.value_rm),
    .wr_en     (bus.wb_wb_en),
    .wr_addr   (bus.wb_dest),
    .wr_data   (bus.wb_value)
  );

  assign bus.wb_en         = ctrl_c.wb_en;
  assign bus.mem_r_en      = ctrl_c.mem_r_en;
  assign bus.mem_w_en      = ctrl_c.mem_w_en;
  assign bus.b             = ctrl_c.b;
  assign bus.s             = ctrl_c.s;
  assign bus.exe_cmd       = ctrl_c.exe_cmd;
  assign bus.pc            = bus.pc_in;
  assign bus.shift_operand = bus.instruction[11:0];
  assign bus.imm           = i_bit;
  assign bus.imm_signed_24 = bus.instruction[23:0];
  assign bus.dest          = rd;
  assign bus.src_1         = rn;
  assign bus.src_2         = src_2_c;
  assign bus.two_src       = ~i_bit | dec_c.mem_w_en;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table, write-back/reset sequences, random vs model.
module tb_id_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_if bus();

  id_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  sr;
    logic        hz;
    logic [4:0]  ctl;   // {wb_en, mem_r_en, mem_w_en, b, s}
    logic [3:0]  exe;
    logic [3:0]  src2;
    logic        two;
    logic [31:0] vrn;
    logic [31:0] vrm;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rf_m [15];
  // ALU command by opcode; -1 marks opcodes the decoder does not support.
  int alu_cmd [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};
  vec_t tbl [17];

  // Reference register file: reset to index values, writes land on the rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) rf_m[i] <= 32'(i);
    end else if (bus.wb_wb_en && bus.wb_dest != 4'hF) begin
      rf_m[bus.wb_dest] <= bus.wb_value;
    end
  end

  function automatic logic [31:0] rd_m(input logic [3:0] a);
    if (a == 4'hF) return 32'h0;
    if (bus.wb_wb_en && bus.wb_dest == a) return bus.wb_value;
    return rf_m[a];
  endfunction

  function automatic vec_t model(input logic [31:0] ins, input logic [3:0] f, input logic hz);
    vec_t  e;
    bit    n, z, c, v;
    bit [15:0] ctab;
    bit    memw;
    int    op;
    {n, z, c, v} = f;
    ctab = {1'b0, 1'b1, z | (n != v), !z && (n == v), n != v, n == v, !c || z, c && !z,
            !v, v, !n, n, !c, c, !z, z};
    op   = int'(ins[24:21]);
    e.ins = ins; e.sr = f; e.hz = hz;
    e.ctl = 5'b0; e.exe = 4'h0;
    if (ins[27:26] == 2'b00 && alu_cmd[op] >= 0) begin
      e.ctl = {(op != 8 && op != 10), 3'b000, ins[20]};
      e.exe = 4'(alu_cmd[op]);
    end else if (ins[27:26] == 2'b01) begin
      e.ctl = ins[20] ? 5'b11000 : 5'b00100;
      e.exe = 4'h2;
    end else if (ins[27:26] == 2'b10 && !ins[24]) begin
      e.ctl = 5'b00010;
    end
    memw  = (ins[27:26] == 2'b01) && !ins[20];
    e.src2 = memw ? ins[15:12] : ins[3:0];
    e.two  = !ins[25] || memw;
    e.vrn  = rd_m(ins[19:16]);
    e.vrm  = rd_m(e.src2);
    if (hz || !ctab[ins[31:28]]) begin
      e.ctl = 5'b0;
      e.exe = 4'h0;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input vec_t e, input logic [31:0] pc_exp);
    chk({tag, ".ctl"}, 32'({bus.wb_en, bus.mem_r_en, bus.mem_w_en, bus.b, bus.s}), 32'(e.ctl));
    chk({tag, ".exe_cmd"}, 32'(bus.exe_cmd), 32'(e.exe));
    chk({tag, ".src_2"}, 32'(bus.src_2), 32'(e.src2));
    chk({tag, ".two_src"}, 32'(bus.two_src), 32'(e.two));
    chk({tag, ".value_rn"}, bus.value_rn, e.vrn);
    chk({tag, ".value_rm"}, bus.value_rm, e.vrm);
    chk({tag, ".dest"}, 32'(bus.dest), 32'(e.ins[15:12]));
    chk({tag, ".src_1"}, 32'(bus.src_1), 32'(e.ins[19:16]));
    chk({tag, ".pc"}, bus.pc, pc_exp);
    chk({tag, ".shift_op"}, 32'(bus.shift_operand), 32'(e.ins[11:0]));
    chk({tag, ".imm"}, 32'(bus.imm), 32'(e.ins[25]));
    chk({tag, ".imm24"}, 32'(bus.imm_signed_24), 32'(e.ins[23:0]));
  endtask

  task automatic drive(input logic [31:0] ins, input logic [3:0] f, input logic hz,
                       input logic we, input logic [3:0] wd, input logic [31:0] wv,
                       input logic [31:0] pcv);
    @(negedge clk);
    bus.instruction = ins; bus.sr = f; bus.hazard = hz;
    bus.wb_wb_en = we; bus.wb_dest = wd; bus.wb_value = wv; bus.pc_in = pcv;
    #1;
  endtask

  initial begin
    logic [31:0] ins, pcv;
    vec_t e;

    tbl[0]  = '{32'hE0810002, 4'h0, 1'b0, 5'b10000, 4'h2, 4'h2, 1'b1, 32'd1, 32'd2};
    tbl[1]  = '{32'hE5854000, 4'h0, 1'b0, 5'b00100, 4'h2, 4'h4, 1'b1, 32'd5, 32'd4};
    tbl[2]  = '{32'hE5854000, 4'h0, 1'b1, 5'b00000, 4'h0, 4'h4, 1'b1, 32'd5, 32'd4};
    tbl[3]  = '{32'hEA000010, 4'h0, 1'b0, 5'b00010, 4'h0, 4'h0, 1'b0, 32'd0, 32'd0};
    tbl[4]  = '{32'h10810002, 4'h4, 1'b0, 5'b00000, 4'h0, 4'h2, 1'b1, 32'd1, 32'd2};
    tbl[5]  = '{32'h00810002, 4'h4, 1'b0, 5'b10000, 4'h2, 4'h2, 1'b1, 32'd1, 32'd2};
    tbl[6]  = '{32'hE5954000, 4'h0, 1'b0, 5'b11000, 4'h2, 4'h0, 1'b1, 32'd5, 32'd0};
    tbl[7]  = '{32'hE3A01005, 4'h0, 1'b0, 5'b10000, 4'h1, 4'h5, 1'b0, 32'd0, 32'd5};
    tbl[8]  = '{32'hE1530004, 4'h0, 1'b0, 5'b00001, 4'h4, 4'h4, 1'b1, 32'd3, 32'd4};
    tbl[9]  = '{32'hE0610002, 4'h0, 1'b0, 5'b00000, 4'h0, 4'h2, 1'b1, 32'd1, 32'd2};
    tbl[10] = '{32'hF0810002, 4'h0, 1'b0, 5'b00000, 4'h0, 4'h2, 1'b1, 32'd1, 32'd2};
    tbl[11] = '{32'hA0810002, 4'h9, 1'b0, 5'b10000, 4'h2, 4'h2, 1'b1, 32'd1, 32'd2};
    tbl[12] = '{32'hE08F000F, 4'h0, 1'b0, 5'b10000, 4'h2, 4'hF, 1'b1, 32'd0, 32'd0};
    tbl[13] = '{32'h80810002, 4'h2, 1'b0, 5'b10000, 4'h2, 4'h2, 1'b1, 32'd1, 32'd2};
    tbl[14] = '{32'hE1100001, 4'h0, 1'b0, 5'b00001, 4'h6, 4'h1, 1'b1, 32'd0, 32'd1};
    tbl[15] = '{32'hE1E02003, 4'h0, 1'b0, 5'b10000, 4'h9, 4'h3, 1'b1, 32'd0, 32'd3};
    tbl[16] = '{32'hB0810002, 4'h9, 1'b0, 5'b00000, 4'h0, 4'h2, 1'b1, 32'd1, 32'd2};

    rst = 1'b1;
    bus.instruction = 32'hE0870000; bus.sr = 4'h0; bus.hazard = 1'b0;
    bus.wb_wb_en = 1'b0; bus.wb_dest = 4'h0; bus.wb_value = 32'h0; bus.pc_in = 32'h0;
    #2;
    chk("rst_r7_during_reset", bus.value_rn, 32'd7);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 15; i++) begin
      drive({12'hE08, 4'(i), 16'h0000}, 4'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      chk($sformatf("reset_r%0d", i), bus.value_rn, 32'(i));
    end

    for (int i = 0; i < 17; i++) begin
      pcv = 32'h100 + 32'(4 * i);
      drive(tbl[i].ins, tbl[i].sr, tbl[i].hz, 1'b0, 4'h0, 32'h0, pcv);
      check_out($sformatf("vec%0d", i), tbl[i], pcv);
    end

    // Write-through bypass, then the stored value after the edge.
    drive(32'hE0830000, 4'h0, 1'b0, 1'b1, 4'd3, 32'hDEADBEEF, 32'h0);
    chk("bypass_r3_same_cycle", bus.value_rn, 32'hDEADBEEF);
    drive(32'hE0830000, 4'h0, 1'b0, 1'b0, 4'd3, 32'h0, 32'h0);
    chk("bypass_r3_next_cycle", bus.value_rn, 32'hDEADBEEF);

    // Writes to R15 are dropped and R15 always reads zero.
    drive(32'hE08F000F, 4'h0, 1'b0, 1'b1, 4'hF, 32'h12345678, 32'h0);
    chk("r15_write_same_cycle", bus.value_rn, 32'h0);
    drive(32'hE08F000F, 4'h0, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    chk("r15_write_next_cycle", bus.value_rm, 32'h0);

    // Reset asserted while a write-back to R2 is pending wins over the write.
    drive(32'hE0820000, 4'h0, 1'b0, 1'b1, 4'd2, 32'd55, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.wb_wb_en = 1'b0;
    #1;
    chk("rst_mid_write_r2", bus.value_rn, 32'd2);
    drive(32'hE0830000, 4'h0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    chk("rst_restores_r3", bus.value_rn, 32'd3);

    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      if ($urandom_range(1, 0) == 1) ins[31:28] = 4'hE;
      pcv = $urandom;
      drive(ins, 4'($urandom_range(15, 0)), ($urandom_range(7, 0) == 0),
            ($urandom_range(1, 0) == 1), 4'($urandom_range(15, 0)), $urandom, pcv);
      e = model(ins, bus.sr, bus.hazard);
      check_out($sformatf("rnd%0d", i), e, pcv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
